// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared defaults and helpers for the handshake master/slave pair
package hs_pkg;

    localparam int HS_WIDTH   = 8;
    localparam int HS_DEPTH   = 4;
    localparam int XFER_CNT_W = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// rtl/hs_sync_fifo.sv - single-clock FIFO storage with pointers, count and full/empty
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Full/empty come from the registered count, so a push while full is refused even alongside a pop.
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/hs_master_fifo.sv
// rtl/hs_master_fifo.sv - buffered valid/ready master feeding the handshake slave stage
module hs_master_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  full,
    output logic                  overflow,
    output logic                  m_valid,
    output logic [WIDTH-1:0]      m_data,
    input  logic                  m_ready,
    output logic [AW+1:0]         level,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    logic [WIDTH-1:0]      fifo_rdata;
    logic [AW:0]           fifo_count;
    logic                  fifo_full, fifo_empty, fifo_pop, xfer;
    logic                  m_valid_q, m_valid_d;
    logic [WIDTH-1:0]      m_data_q, m_data_d;
    logic                  overflow_q, overflow_d;
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    hs_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .rdata     (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Refill the output register whenever it is empty or being consumed this edge.
    assign xfer     = m_valid_q & m_ready;
    assign fifo_pop = ~fifo_empty & (~m_valid_q | m_ready);

    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        overflow_d = overflow_q | (wr_en & fifo_full);
        xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(xfer);
        if (fifo_pop) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_rdata;
        end else if (xfer) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            overflow_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            overflow_q <= overflow_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign xfer_cnt = xfer_cnt_q;
    assign level    = {1'b0, fifo_count} + {{(AW+1){1'b0}}, m_valid_q};

endmodule

// File: tb/tb_hs_master_fifo.sv
// tb/tb_hs_master_fifo.sv - self-checking bench for hs_master_fifo
module tb_hs_master_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        m_ready = 1'b0;
    logic        full, overflow, m_valid;
    logic [7:0]  m_data;
    logic [3:0]  level;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    hs_master_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .overflow (overflow),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level    (level),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference: a queue of buffered words plus one output slot.
    logic [7:0] mdl_q[$];
    bit         mdl_ov;
    logic [7:0] mdl_od;
    bit         mdl_ovf;
    int         mdl_cnt;

    function automatic void model_reset();
        mdl_q.delete();
        mdl_ov  = 0;
        mdl_od  = 8'h00;
        mdl_ovf = 0;
        mdl_cnt = 0;
    endfunction

    function automatic void model_edge(input bit we, input logic [7:0] wd, input bit rdy);
        bit was_full;
        bit xfer;
        bit load;
        was_full = (mdl_q.size() == DEPTH);
        xfer     = mdl_ov && rdy;
        load     = (mdl_q.size() > 0) && (!mdl_ov || rdy);
        if (xfer) mdl_cnt = (mdl_cnt + 1) % 65536;
        if (load) begin
            mdl_od = mdl_q.pop_front();
            mdl_ov = 1;
        end else if (xfer) begin
            mdl_ov = 0;
        end
        if (we && !was_full) mdl_q.push_back(wd);
        else if (we) mdl_ovf = 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".m_valid"}, 32'(m_valid), 32'(mdl_ov));
        check({tag, ".m_data"}, 32'(m_data), 32'(mdl_od));
        check({tag, ".full"}, 32'(full), 32'(mdl_q.size() == DEPTH));
        check({tag, ".level"}, 32'(level), 32'(mdl_q.size() + int'(mdl_ov)));
        check({tag, ".overflow"}, 32'(overflow), 32'(mdl_ovf));
        check({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(mdl_cnt));
    endtask

    task automatic step(input bit we, input logic [7:0] wd, input bit rdy, input bit chk, input string tag);
        wr_en   = we;
        wr_data = wd;
        m_ready = rdy;
        @(posedge clk);
        model_edge(we, wd, rdy);
        #1;
        if (chk) compare_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         we;
        logic [7:0] wd;
        bit         rdy;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_full;
        logic [3:0] e_level;
        bit         e_ovf;
        logic [15:0] e_xfer;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit seen, full_seen;
        int gaps, guard;

        vecs[0]  = '{1, 8'h01, 0, 0, 8'h00, 0, 4'd1, 0, 16'd0};
        vecs[1]  = '{1, 8'h02, 0, 1, 8'h01, 0, 4'd2, 0, 16'd0};
        vecs[2]  = '{1, 8'h03, 0, 1, 8'h01, 0, 4'd3, 0, 16'd0};
        vecs[3]  = '{1, 8'h04, 0, 1, 8'h01, 0, 4'd4, 0, 16'd0};
        vecs[4]  = '{1, 8'h05, 0, 1, 8'h01, 1, 4'd5, 0, 16'd0};
        vecs[5]  = '{1, 8'h06, 0, 1, 8'h01, 1, 4'd5, 1, 16'd0};
        vecs[6]  = '{0, 8'h00, 1, 1, 8'h02, 0, 4'd4, 1, 16'd1};
        vecs[7]  = '{0, 8'h00, 1, 1, 8'h03, 0, 4'd3, 1, 16'd2};
        vecs[8]  = '{0, 8'h00, 1, 1, 8'h04, 0, 4'd2, 1, 16'd3};
        vecs[9]  = '{0, 8'h00, 1, 1, 8'h05, 0, 4'd1, 1, 16'd4};
        vecs[10] = '{0, 8'h00, 1, 0, 8'h05, 0, 4'd0, 1, 16'd5};

        do_reset();
        check("reset.m_valid", 32'(m_valid), 0);
        check("reset.m_data", 32'(m_data), 0);
        check("reset.full", 32'(full), 0);
        check("reset.overflow", 32'(overflow), 0);
        check("reset.level", 32'(level), 0);
        check("reset.xfer_cnt", 32'(xfer_cnt), 0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].rdy, 0, "fill");
            check($sformatf("fill[%0d].m_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
            check($sformatf("fill[%0d].m_data", i), 32'(m_data), 32'(vecs[i].e_data));
            check($sformatf("fill[%0d].full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("fill[%0d].level", i), 32'(level), 32'(vecs[i].e_level));
            check($sformatf("fill[%0d].overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            check($sformatf("fill[%0d].xfer_cnt", i), 32'(xfer_cnt), 32'(vecs[i].e_xfer));
        end

        do_reset();
        step(1, 8'hA5, 0, 1, "single.wr");
        check("single.latency_valid", 32'(m_valid), 0);
        step(0, 8'h00, 0, 1, "single.load");
        check("single.valid", 32'(m_valid), 1);
        check("single.data", 32'(m_data), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0, 1, "single.stall");
            check("single.hold_valid", 32'(m_valid), 1);
            check("single.hold_data", 32'(m_data), 32'hA5);
        end
        step(0, 8'h00, 1, 1, "single.xfer");
        check("single.done_valid", 32'(m_valid), 0);
        check("single.done_xfer", 32'(xfer_cnt), 1);
        check("single.done_level", 32'(level), 0);

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1, 1, "rand");
        end

        do_reset();
        seen = 0;
        full_seen = 0;
        gaps = 0;
        for (int i = 0; i < 34; i++) begin
            step(i < 32, 8'(i), 1, 1, "stream");
            if (full) full_seen = 1;
            if (m_valid) seen = 1;
            else if (seen && xfer_cnt < 32) gaps++;
        end
        check("stream.gaps", 32'(gaps), 0);
        check("stream.full_seen", 32'(full_seen), 0);
        check("stream.xfer_cnt", 32'(xfer_cnt), 32);

        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 1, "simul.fill");
        check("simul.pre_level", 32'(level), 4);
        step(1, 8'h77, 1, 1, "simul.edge");
        check("simul.level", 32'(level), 4);
        check("simul.full", 32'(full), 0);
        check("simul.data", 32'(m_data), 2);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 1, "simul.drain");
        check("simul.xfer_cnt", 32'(xfer_cnt), 5);

        do_reset();
        for (int i = 0; i < 4; i++) step(i < 3, 8'(8'h30 + i), 0, 1, "midrst.fill");
        check("midrst.pre_valid", 32'(m_valid), 1);
        #3 rst = 1'b1;
        #1;
        check("midrst.m_valid", 32'(m_valid), 0);
        check("midrst.m_data", 32'(m_data), 0);
        check("midrst.level", 32'(level), 0);
        check("midrst.xfer_cnt", 32'(xfer_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, "midrst.idle");
        check("midrst.after_valid", 32'(m_valid), 0);

        do_reset();
        guard = 0;
        while (mdl_cnt != 16'hFFFF && guard < 70000) begin
            step(1, 8'(guard), 1, 0, "wrap");
            guard++;
        end
        check("wrap.reached", 32'(mdl_cnt), 32'hFFFF);
        check("wrap.ffff", 32'(xfer_cnt), 32'hFFFF);
        step(1, 8'h00, 1, 1, "wrap.edge");
        check("wrap.zero", 32'(xfer_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
